cpu_load_run_ctrl: RTL
======================

# cpu_load_run_ctrl

Sequencing controller between the UART receiver, the instruction memory and the CPU core inside TOP_CPU. It packs received UART bytes into 16-bit instruction words and writes them to instruction memory. It holds the core in reset while loading, then releases it on start. It gates core execution for continuous run, single-step execution and halt.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width (words)
- IDLE_TIMEOUT, 20000, idle i_clk cycles after the last byte that end loading

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset; one clock; all state and outputs take reset values on the next edge
- i_rx_valid  in  1  one-cycle strobe from UART receiver, byte available
- i_rx_data  in  8  received byte
- i_start_cpu  in  1  level, already synchronized; request to leave loading and run
- i_step_mode  in  1  level; 1 = single-step execution
- i_next_instr  in  1  level, already synchronized; rising edge = advance one instruction
- i_instr_boundary  in  1  one-cycle pulse from core at each instruction fetch
- i_halt  in  1  core decoded HALT
- o_imem_we  out  1  instruction memory write strobe
- o_imem_addr  out  ADDR_W  write address
- o_imem_wdata  out  16  write data
- o_instr_transmit_done  out  1  loading finished (sticky until reset)
- o_max_addr  out  ADDR_W  address of last word written
- o_cpu_rst  out  1  core held in reset
- o_cpu_en  out  1  core clock enable
- o_halt  out  1  core halted (sticky)
- o_load_err  out  1  sticky: odd byte count or memory overflow
- o_state  out  3  current state encoding, for debug LEDs

## Operation
- States: LOAD(0), READY(1), RUN(2), STEP_WAIT(3), HALTED(4).
- LOAD:
  - Byte assembly uses a 1-bit phase. The first byte is the high byte [15:8]; the second byte is the low byte [7:0].
  - On the second byte, the word is written at the current address. The address then increments and o_max_addr takes the written address.
  - A 32-bit-safe idle counter clears on every i_rx_valid and saturates at IDLE_TIMEOUT.
- LOAD exits to READY on either of these, provided at least one word has been written:
  - the idle counter reaches IDLE_TIMEOUT, or
  - i_start_cpu is high.
- If no word has been written, LOAD stays in LOAD.
- On leaving LOAD:
  - o_instr_transmit_done is set.
  - A pending half-word (phase = 1) is discarded and o_load_err is set.
- READY: i_start_cpu high → RUN. If LOAD exited via start, READY → RUN on the next cycle.
- RUN:
  - i_halt → HALTED.
  - If i_step_mode = 1 and i_instr_boundary = 1 → STEP_WAIT.
- STEP_WAIT:
  - Rising edge of i_next_instr → RUN; exactly one instruction executes before the next boundary.
  - i_step_mode falling to 0 → RUN.
  - i_halt → HALTED.
- HALTED: terminal until i_rst.
- o_cpu_rst = 1 in LOAD and READY; 0 otherwise.
- o_cpu_en = 1 only in RUN.
- Overflow: once address 2^ADDR_W−1 has been written, further words are dropped, o_load_err is set, and o_max_addr holds at 2^ADDR_W−1.
- Bytes arriving outside LOAD are ignored.

## Timing
- Reset values:
  - State LOAD.
  - o_imem_we = 0, o_imem_addr = 0, o_imem_wdata = 0.
  - o_instr_transmit_done = 0, o_max_addr = 0.
  - o_cpu_rst = 1, o_cpu_en = 0.
  - o_halt = 0, o_load_err = 0, o_state = 0.
- All outputs are registered.
- Write latency: o_imem_we pulses for one cycle, the cycle after the second byte's i_rx_valid. Address and data are valid in the same cycle.
- Transition into STEP_WAIT: o_cpu_en drops one cycle after the i_instr_boundary pulse, so the fetched instruction's first cycle is consumed.
- i_next_instr edge detection uses a registered previous value. A held-high level advances only once.
- Simultaneous i_halt and i_instr_boundary in RUN: HALTED wins.
- i_rst mid-load discards the partial word and restarts at address 0.

## Configuration
- STEP_EXEC_EN defined: single-step path (STEP_WAIT, edge detector) compiled in.
- STEP_EXEC_EN undefined:
  - i_step_mode and i_next_instr are ignored.
  - STEP_WAIT is unreachable and removed.
  - RUN exits only on i_halt.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum and its encodings;
  - INSTR_W = 16;
  - the default IDLE_TIMEOUT constant.
- One sub-module: uart_word_packer. It covers byte phase, word assembly, the address counter, overflow and the write strobe. The FSM, idle counter and execution gating stay in the top.

## Test plan
- Load: send bytes 0x41,0x00,0x80,0x80, then idle ≥ IDLE_TIMEOUT → writes 0x4100 at 0 and 0x8080 at 1; o_max_addr = 1; o_instr_transmit_done = 1; o_load_err = 0; state READY.
- Start mid-idle: 4 bytes, then i_start_cpu = 1 after 100 cycles → done = 1, READY then RUN on consecutive cycles, o_cpu_rst falls, o_cpu_en rises.
- Odd count: 3 bytes then timeout → one word written, o_load_err = 1, o_max_addr = 0.
- Step: i_step_mode = 1, run, boundary pulse → o_cpu_en = 0 next cycle. Hold i_next_instr high 50 cycles → exactly one RUN interval, back to STEP_WAIT at the next boundary.
- Halt: i_halt together with a boundary in RUN → HALTED; o_halt = 1; o_cpu_en = 0; i_start_cpu has no effect until i_rst.
- Overflow with ADDR_W = 2: 10 bytes → 4 writes (addr 0–3), o_load_err = 1, o_max_addr = 3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU load/run controller.
package cpu_ctrl_pkg;

    // Controller states; the encodings are shown on the debug LEDs.
    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_READY     = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    localparam int INSTR_W          = 16;
    localparam int IDLE_TIMEOUT_DEF = 20000;

endpackage

// File: rtl/uart_word_packer.sv
// Packs UART bytes (high byte first) into instruction words and writes them
// to instruction memory. Once the last address has been written, further
// words are dropped and the overflow flag latches.
module uart_word_packer
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_flush,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_imem_wdata,
    output logic [ADDR_W-1:0]  o_max_addr,
    output logic               o_any_written,
    output logic               o_phase,
    output logic               o_ovf
);

    logic              phase_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic              full_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [INSTR_W-1:0] wdata_q;
    logic [ADDR_W-1:0] max_q;
    logic              any_q;
    logic              ovf_q;

    // Byte phase, word assembly, address counter and one-cycle write strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
            addr_q  <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            max_q   <= '0;
            any_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (i_flush) begin
                // Leaving load: a pending high byte is thrown away.
                phase_q <= 1'b0;
            end else if (i_en && i_rx_valid) begin
                if (!phase_q) begin
                    hi_q    <= i_rx_data;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    if (full_q) begin
                        ovf_q <= 1'b1;
                    end else begin
                        we_q    <= 1'b1;
                        waddr_q <= addr_q;
                        wdata_q <= {hi_q, i_rx_data};
                        max_q   <= addr_q;
                        any_q   <= 1'b1;
                        // Last address written: stop counting, later words drop.
                        if (addr_q == '1) full_q <= 1'b1;
                        else              addr_q <= addr_q + 1'b1;
                    end
                end
            end
        end
    end

    assign o_imem_we     = we_q;
    assign o_imem_addr   = waddr_q;
    assign o_imem_wdata  = wdata_q;
    assign o_max_addr    = max_q;
    assign o_any_written = any_q;
    assign o_phase       = phase_q;
    assign o_ovf         = ovf_q;

endmodule

// File: rtl/cpu_load_run_ctrl.sv
// Load/run sequencer: loads the program over UART, holds the core in reset
// until started, then gates execution (run, single-step, halt).
// Optional feature macro: STEP_EXEC_EN (single-step path).
module cpu_load_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_start_cpu,
    input  logic               i_step_mode,
    input  logic               i_next_instr,
    input  logic               i_instr_boundary,
    input  logic               i_halt,
    output logic               o_imem_we,
    output logic [ADDR_W-1:0]  o_imem_addr,
    output logic [INSTR_W-1:0] o_imem_wdata,
    output logic               o_instr_transmit_done,
    output logic [ADDR_W-1:0]  o_max_addr,
    output logic               o_cpu_rst,
    output logic               o_cpu_en,
    output logic               o_halt,
    output logic               o_load_err,
    output logic [2:0]         o_state
);

    state_t      state_q, state_d;
    logic [31:0] idle_q;
    logic        start_seen_q;
    logic        done_q, err_q, halt_q, cpu_rst_q, cpu_en_q;
    logic        pk_any, pk_phase, pk_ovf;
    logic        load_exit;
    logic        next_rise;

    // Loading ends once something was written and either the line went idle
    // or the user asked to start.
    assign load_exit = (state_q == ST_LOAD) && pk_any &&
                       ((idle_q == 32'(IDLE_TIMEOUT)) || i_start_cpu);

    uart_word_packer #(.ADDR_W(ADDR_W)) u_packer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          ((state_q == ST_LOAD) && !load_exit),
        .i_flush       (load_exit),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .o_imem_we     (o_imem_we),
        .o_imem_addr   (o_imem_addr),
        .o_imem_wdata  (o_imem_wdata),
        .o_max_addr    (o_max_addr),
        .o_any_written (pk_any),
        .o_phase       (pk_phase),
        .o_ovf         (pk_ovf)
    );

    // Idle counter: cleared by every byte, saturates at the timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_rx_valid)
            idle_q <= '0;
        else if ((state_q == ST_LOAD) && (idle_q != 32'(IDLE_TIMEOUT)))
            idle_q <= idle_q + 32'd1;
    end

`ifdef STEP_EXEC_EN
    logic next_prev_q;

    // Previous level of the next-instruction button, for rising-edge detect.
    always_ff @(posedge i_clk) begin
        if (i_rst) next_prev_q <= 1'b0;
        else       next_prev_q <= i_next_instr;
    end

    assign next_rise = i_next_instr && !next_prev_q;
`else
    logic unused_step;
    assign unused_step = i_step_mode ^ i_next_instr;
    assign next_rise   = 1'b0;
`endif

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (load_exit) state_d = ST_READY;
            ST_READY:  if (i_start_cpu || start_seen_q) state_d = ST_RUN;
            ST_RUN: begin
                if (i_halt) state_d = ST_HALTED;
`ifdef STEP_EXEC_EN
                else if (i_step_mode && i_instr_boundary) state_d = ST_STEP_WAIT;
`endif
            end
`ifdef STEP_EXEC_EN
            ST_STEP_WAIT: begin
                if (i_halt)                        state_d = ST_HALTED;
                else if (next_rise || !i_step_mode) state_d = ST_RUN;
            end
`endif
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_LOAD;
        endcase
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_LOAD;
            start_seen_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            halt_q       <= 1'b0;
            cpu_rst_q    <= 1'b1;
            cpu_en_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= (state_d == ST_LOAD) || (state_d == ST_READY);
            cpu_en_q  <= (state_d == ST_RUN);
            halt_q    <= halt_q || (state_d == ST_HALTED);
            if (load_exit) begin
                done_q       <= 1'b1;
                start_seen_q <= i_start_cpu;
                if (pk_phase) err_q <= 1'b1;
            end
            if (pk_ovf) err_q <= 1'b1;
        end
    end

    assign o_instr_transmit_done = done_q;
    assign o_load_err            = err_q;
    assign o_halt                = halt_q;
    assign o_cpu_rst             = cpu_rst_q;
    assign o_cpu_en              = cpu_en_q;
    assign o_state               = state_q;

endmodule
